display_share_arbiter: RTL and testbench
========================================

// Module: display_share_arbiter
// PURPOSE
//  Shares the single 4-digit 7-segment display between 3 requesters (e.g. counter, status, error code).
//  Round-robin arbiter with a minimum on-screen hold time. The display driver cannot read a
//  different source every cycle, so a granted source keeps the display for at least HOLD_CYCLES.
//  Sits directly upstream of the display driver: drives its hex_0_in..hex_3_in and dp_in inputs.
// PARAMETERS
//  HOLD_CYCLES  200  min clk cycles a granted source stays on the display; legal range >= 1
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   synchronous reset, active-low (0 = reset)
//  req_in       in   3   req_in[i]=1: source i wants the display; level, held while it wants it
//  val_0_in     in   16  source 0 value, [3:0]=digit 0 ... [15:12]=digit 3
//  val_1_in     in   16  source 1 value, same packing
//  val_2_in     in   16  source 2 value, same packing
//  dp_0_in      in   4   source 0 decimal points, bit i = digit i
//  dp_1_in      in   4   source 1 decimal points
//  dp_2_in      in   4   source 2 decimal points
//  ack_out      out  3   one-hot, 1-cycle pulse on the cycle a source gains the grant
//  grant_out    out  2   index of the current owner (0..2); meaningful only when busy_out=1
//  busy_out     out  1   1 while in SHOW
//  hex_0_out    out  4   digit 0 to display driver (hex_1_out..hex_3_out identical, digits 1..3)
//  hex_1_out    out  4   digit 1
//  hex_2_out    out  4   digit 2
//  hex_3_out    out  4   digit 3
//  dp_out       out  4   decimal points to display driver
//  blank_out    out  1   1 = nobody owns the display; driver shows all segments off
// BEHAVIOUR
//  - Reset (rst=0 at edge): state=IDLE; ack_out=0, grant_out=0, busy_out=0, hex_*=0, dp_out=0,
//    blank_out=1; hold counter=0; rr pointer last=2, so source 0 has top priority after reset.
//  - Reset mid-SHOW aborts immediately: reset values on the same edge. No ack_out is issued.
//  - FSM states: IDLE, SHOW. All outputs registered.
//  - Priority order: last+1, last+2, last (mod 3).
//  - IDLE: on an edge with any req_in=1, the winner w by priority order is granted.
//    At that same edge: state=SHOW, grant_out=w, ack_out[w]=1, busy_out=1, blank_out=0,
//    hex/dp loaded from source w, counter=0, last=w. Latency req->display = 1 cycle.
//  - SHOW, every edge:
//    - while req_in[grant] is 1, hex/dp track the live source value with 1-cycle latency;
//    - if req_in[grant] drops, hex/dp freeze at their last value;
//    - ack_out returns to 0 one cycle after the grant.
//  - Hold expiry: on the edge where counter == HOLD_CYCLES-1, re-arbitrate.
//    - Other source requesting: grant the next one in priority order (current owner has lowest
//      priority). New ack pulse; counter=0.
//    - Only current owner requesting: keep the grant, no new ack, counter=0.
//    - Nobody requesting: state=IDLE, blank_out=1, busy_out=0, hex/dp=0, grant_out holds.
//  - Otherwise the counter increments. Width = $clog2(HOLD_CYCLES+1); never wraps, because it
//    restarts at expiry.
//  - Owner releasing early does not shorten the hold; the frozen value stays until expiry.
//  - HOLD_CYCLES=1: re-arbitration on every SHOW edge; with all 3 requesting, grant
//    rotates 0,1,2,0...
//  - Simultaneous requests in IDLE: the priority order decides; no cycle is ever granted to 2 sources.
// TESTING  (bench uses HOLD_CYCLES=4)
//  1 rst=0 for 2 cycles, then rst=1, req_in=0 -> blank_out=1, busy_out=0, hex_*=0, dp_out=0, ack_out=0
//  2 req_in=3'b001, val_0_in=16'hfa51, dp_0_in=4'ha -> next edge: ack_out=3'b001 for 1 cycle,
//    grant_out=0, hex_3..0 = f,a,5,1, dp_out=4'ha, blank_out=0
//  3 req_in=3'b111 from IDLE after reset -> grants 0,1,2,0 each lasting exactly 4 cycles;
//    one ack pulse per switch
//  4 source 1 alone holds display, req drops after 1 cycle, val_1_in changes -> hex frozen until
//    4th cycle, then IDLE, blank_out=1
//  5 source 2 sole requester for 12 cycles -> grant stays 2, exactly one ack pulse,
//    hex tracks val_2_in 1 cycle late
//  6 rst=0 asserted in SHOW at counter=2 -> all outputs at reset values on that edge;
//    after release with req_in=3'b110 -> source 1 granted first

Source files
------------

// File: rtl/display_share_arbiter.sv
// -----------------------------------------------------------------------------
// display_share_arbiter
//
// Shares one 4-digit 7-segment display between three sources. A round-robin
// arbiter hands the display to one source at a time, and the winner keeps it
// for at least HOLD_CYCLES clocks so the downstream driver sees a stable
// source. All outputs are registered and feed the display driver directly.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous reset, active-low (0 = reset)
//   req_in      in   [2:0]  level request per source
//   val_N_in    in   [15:0] source N digits, [3:0]=digit 0 .. [15:12]=digit 3
//   dp_N_in     in   [3:0]  source N decimal points, bit i = digit i
//   ack_out     out  [2:0]  one-hot pulse on the cycle a source gains the grant
//   grant_out   out  [1:0]  current owner index (valid while busy_out=1)
//   busy_out    out         1 while a source owns the display
//   hex_N_out   out  [3:0]  digit N to the display driver
//   dp_out      out  [3:0]  decimal points to the display driver
//   blank_out   out         1 when nobody owns the display
// -----------------------------------------------------------------------------
module display_share_arbiter #(
  parameter int HOLD_CYCLES = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_in,
  input  logic [15:0] val_0_in,
  input  logic [15:0] val_1_in,
  input  logic [15:0] val_2_in,
  input  logic [3:0]  dp_0_in,
  input  logic [3:0]  dp_1_in,
  input  logic [3:0]  dp_2_in,
  output logic [2:0]  ack_out,
  output logic [1:0]  grant_out,
  output logic        busy_out,
  output logic [3:0]  hex_0_out,
  output logic [3:0]  hex_1_out,
  output logic [3:0]  hex_2_out,
  output logic [3:0]  hex_3_out,
  output logic [3:0]  dp_out,
  output logic        blank_out
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {IDLE, SHOW} state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      grant_q, grant_d;
  logic [2:0]      ack_q, ack_d;
  logic [15:0]     hex_q, hex_d;
  logic [3:0]      dp_q, dp_d;

  pick_t           win;
  logic [15:0]     owner_val, win_val;
  logic [3:0]      owner_dp, win_dp;
  logic            hold_done;

  // Round-robin pick: search last+1, last+2, last (mod 3); the previous
  // owner therefore always comes last.
  function automatic pick_t pick_winner(input logic [2:0] req, input logic [1:0] last);
    pick_t      res;
    logic [1:0] cand;
    res = '0;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'((int'(last) + k) % 3);
      if (!res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

  function automatic logic [15:0] sel_val(input logic [1:0] idx, input logic [15:0] v0,
                                          input logic [15:0] v1, input logic [15:0] v2);
    case (idx)
      2'd0:    return v0;
      2'd1:    return v1;
      default: return v2;
    endcase
  endfunction

  function automatic logic [3:0] sel_dp(input logic [1:0] idx, input logic [3:0] d0,
                                        input logic [3:0] d1, input logic [3:0] d2);
    case (idx)
      2'd0:    return d0;
      2'd1:    return d1;
      default: return d2;
    endcase
  endfunction

  // While in SHOW, last_q always equals the owner, so the same pick gives
  // the owner lowest priority at hold expiry.
  assign win       = pick_winner(req_in, last_q);
  assign win_val   = sel_val(win.idx, val_0_in, val_1_in, val_2_in);
  assign win_dp    = sel_dp(win.idx, dp_0_in, dp_1_in, dp_2_in);
  assign owner_val = sel_val(grant_q, val_0_in, val_1_in, val_2_in);
  assign owner_dp  = sel_dp(grant_q, dp_0_in, dp_1_in, dp_2_in);
  assign hold_done = (cnt_q == CW'(HOLD_CYCLES - 1));

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    ack_d   = '0;
    hex_d   = hex_q;
    dp_d    = dp_q;

    case (state_q)
      IDLE: begin
        if (win.found) begin
          state_d = SHOW;
          grant_d = win.idx;
          last_d  = win.idx;
          ack_d   = 3'b001 << win.idx;
          hex_d   = win_val;
          dp_d    = win_dp;
          cnt_d   = '0;
        end
      end

      SHOW: begin
        if (hold_done) begin
          cnt_d = '0;
          if (!win.found) begin
            // Nobody wants the display; grant_out keeps the last owner.
            state_d = IDLE;
            hex_d   = '0;
            dp_d    = '0;
          end else if (win.idx != grant_q) begin
            grant_d = win.idx;
            last_d  = win.idx;
            ack_d   = 3'b001 << win.idx;
            hex_d   = win_val;
            dp_d    = win_dp;
          end else if (req_in[grant_q]) begin
            hex_d = owner_val;
            dp_d  = owner_dp;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          // A released owner keeps its frozen value until the hold expires.
          if (req_in[grant_q]) begin
            hex_d = owner_val;
            dp_d  = owner_dp;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd2;
      grant_q <= '0;
      ack_q   <= '0;
      hex_q   <= '0;
      dp_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
    end
  end

  assign ack_out   = ack_q;
  assign grant_out = grant_q;
  assign busy_out  = (state_q == SHOW);
  assign blank_out = (state_q == IDLE);
  assign hex_0_out = hex_q[3:0];
  assign hex_1_out = hex_q[7:4];
  assign hex_2_out = hex_q[11:8];
  assign hex_3_out = hex_q[15:12];
  assign dp_out    = dp_q;

endmodule

// File: tb/tb_display_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_display_share_arbiter
//
// Self-checking bench for display_share_arbiter with HOLD_CYCLES=4. A
// behavioural model (owner index, age since grant, round-robin pointer) is
// advanced on every rising edge from the same inputs; a negedge process
// compares every output with it. Directed scenarios add literal checks, then
// a randomized phase exercises requests, value changes and resets.
// -----------------------------------------------------------------------------
module tb_display_share_arbiter;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0;
  logic [15:0] val [3];
  logic [3:0]  dpi [3];

  logic [2:0]  ack_out;
  logic [1:0]  grant_out;
  logic        busy_out;
  logic [3:0]  hex_0_out, hex_1_out, hex_2_out, hex_3_out;
  logic [3:0]  dp_out;
  logic        blank_out;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  display_share_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req),
    .val_0_in  (val[0]),
    .val_1_in  (val[1]),
    .val_2_in  (val[2]),
    .dp_0_in   (dpi[0]),
    .dp_1_in   (dpi[1]),
    .dp_2_in   (dpi[2]),
    .ack_out   (ack_out),
    .grant_out (grant_out),
    .busy_out  (busy_out),
    .hex_0_out (hex_0_out),
    .hex_1_out (hex_1_out),
    .hex_2_out (hex_2_out),
    .hex_3_out (hex_3_out),
    .dp_out    (dp_out),
    .blank_out (blank_out)
  );

  always #5 clk = ~clk;

  wire [15:0] hex_all = {hex_3_out, hex_2_out, hex_1_out, hex_0_out};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: who owns the display and for how long.
  // ---------------------------------------------------------------------------
  bit          m_show;
  int          m_owner, m_age, m_last;
  logic [15:0] m_hex;
  logic [3:0]  m_dp;
  logic [2:0]  m_ack;

  function automatic int m_pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++)
      if (r[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    if (!rst) begin
      m_show = 0; m_owner = 0; m_age = 0; m_last = 2;
      m_hex = '0; m_dp = '0; m_ack = '0;
    end else begin
      m_ack = '0;
      w = m_pick(req, m_last);
      if (!m_show) begin
        if (w >= 0) begin
          m_show = 1; m_owner = w; m_last = w; m_age = 0;
          m_ack = 3'(1 << w); m_hex = val[w]; m_dp = dpi[w];
        end
      end else if (m_age == HOLD - 1) begin
        m_age = 0;
        if (w < 0) begin
          m_show = 0; m_hex = '0; m_dp = '0;
        end else if (w != m_owner) begin
          m_owner = w; m_last = w;
          m_ack = 3'(1 << w); m_hex = val[w]; m_dp = dpi[w];
        end else begin
          m_hex = val[w]; m_dp = dpi[w];
        end
      end else begin
        m_age++;
        if (req[m_owner]) begin
          m_hex = val[m_owner]; m_dp = dpi[m_owner];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",  busy_out,  m_show);
      check("blank", blank_out, !m_show);
      check("ack",   ack_out,   m_ack);
      check("grant", grant_out, m_owner);
      check("hex",   hex_all,   m_hex);
      check("dp",    dp_out,    m_dp);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int acks;
    logic [15:0] prev;
    for (int i = 0; i < 3; i++) begin
      val[i] = 16'(16'h1111 * (i + 1));
      dpi[i] = 4'(i + 1);
    end

    // 1: reset, then idle with no request.
    do_reset();
    tick();
    check("t1_blank", blank_out, 1);
    check("t1_busy",  busy_out,  0);
    check("t1_hex",   hex_all,   0);
    check("t1_dp",    dp_out,    0);
    check("t1_ack",   ack_out,   0);

    // 2: single grant to source 0, latency one cycle.
    req = 3'b001; val[0] = 16'hfa51; dpi[0] = 4'ha;
    tick();
    check("t2_ack",   ack_out,   3'b001);
    check("t2_grant", grant_out, 0);
    check("t2_hex",   hex_all,   16'hfa51);
    check("t2_dp",    dp_out,    4'ha);
    check("t2_blank", blank_out, 0);
    tick();
    check("t2_ack_pulse", ack_out, 0);

    // 3: all three request from IDLE; 4-cycle slots rotating 0,1,2,0.
    do_reset();
    req = 3'b111;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("t3_grant", grant_out, (k / 4) % 3);
      check("t3_ack", ack_out, (k % 4 == 0) ? (1 << ((k / 4) % 3)) : 0);
    end

    // 4: source 1 releases after one cycle; value frozen until hold expiry.
    do_reset();
    req = 3'b010; val[1] = 16'h1234; dpi[1] = 4'h5;
    tick();
    check("t4_ack", ack_out, 3'b010);
    req = 3'b000; val[1] = 16'h9999; dpi[1] = 4'hf;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_frozen", hex_all, 16'h1234);
      check("t4_busy", busy_out, 1);
    end
    tick();
    check("t4_blank", blank_out, 1);
    check("t4_hex0",  hex_all,   0);
    check("t4_grant_hold", grant_out, 1);

    // 5: source 2 alone for 12 cycles; one ack, hex tracks one cycle late.
    do_reset();
    req = 3'b100;
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      val[2] = 16'($urandom);
      prev = val[2];
      tick();
      if (ack_out != 0) acks++;
      check("t5_grant", grant_out, 2);
      check("t5_track", hex_all, prev);
    end
    check("t5_acks", acks, 1);

    // 6: reset in SHOW at counter=2, then source 1 wins first after release.
    do_reset();
    req = 3'b001;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check("t6_blank", blank_out, 1);
    check("t6_busy",  busy_out,  0);
    check("t6_ack",   ack_out,   0);
    check("t6_hex",   hex_all,   0);
    rst = 1'b1; req = 3'b110;
    tick();
    check("t6_grant", grant_out, 1);
    check("t6_ack1",  ack_out,   3'b010);

    // Randomized phase: sticky random requests, changing values, rare resets.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 1) == 0) val[i] = 16'($urandom);
        if ($urandom_range(0, 3) == 0) dpi[i] = 4'($urandom);
      end
      rst = ($urandom_range(0, 49) != 0);
      tick();
    end
    rst = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
